// File: rtl/rr_sel_arbiter_4ch.sv
`default_nettype none
// ============================================================================
// Module   : rr_sel_arbiter_4ch
// Purpose  : Four-channel round-robin arbiter driving a 4:1 mux select, with
//            done/request-drop release and a hold-time forced release.
// Revision : 1.0  initial release
// ============================================================================
module rr_sel_arbiter_4ch #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0]    c_IDLE     = 1'b0;
  localparam logic [0:0]    c_GRANT    = 1'b1;
  localparam logic [CW-1:0] c_HOLD_MAX = CW'(HOLD_MAX);

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_hold;
  logic [1:0]    r_sel;
  logic          r_timeout;

  logic [1:0]    w_winner;
  logic          w_any_req;
  logic          w_rel_norm;
  logic          w_rel_force;

  assign w_any_req   = |req;
  assign w_rel_norm  = done | ~req[r_sel];
  assign w_rel_force = (r_hold == c_HOLD_MAX);

  // Scan from the farthest offset down so the closest set bit to r_ptr wins.
  always_comb begin
    w_winner = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_winner = r_ptr + 2'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_IDLE) begin
      if (w_any_req) begin
        w_state_nxt = c_GRANT;
      end
    end else begin
      if (w_rel_norm || w_rel_force) begin
        w_state_nxt = c_IDLE;
      end
    end
  end

  // Datapath: pointer, hold counter, latched select and timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= 2'd0;
      r_hold    <= '0;
      r_sel     <= 2'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == c_IDLE) begin
        if (w_any_req) begin
          r_sel  <= w_winner;
          r_hold <= '0;
        end
      end else if (w_rel_norm) begin
        r_ptr <= r_sel + 2'd1;
      end else if (w_rel_force) begin
        r_ptr     <= r_sel + 2'd1;
        r_timeout <= 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  // Output logic: everything derives from registers, so outputs move only on edges
  always_comb begin
    busy    = (r_state == c_GRANT);
    sel     = r_sel;
    timeout = r_timeout;
    gnt     = 4'b0000;
    if (r_state == c_GRANT) begin
      gnt = 4'b0001 << r_sel;
    end
  end

endmodule
`default_nettype wire
